// File: rtl/packet_buffer_reader_pkg.sv
// Shared constants, state encoding and width helper for the packet buffer read path.
package packet_buffer_reader_pkg;

    localparam int BYTE_LEN                   = 8;
    localparam int PACKET_BUFFER_SIZE         = 1024;
    localparam int PACKET_BUFFER_READ_LATENCY = 2;
    localparam int PACKET_READER_MAX_LEN      = 2048;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        IDLE  = 2'd1,
        RUN   = 2'd2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/packet_reader_fifo.sv
// First-word-fall-through skid FIFO: an incoming word is visible at the head in
// the same cycle it arrives, so an empty FIFO adds no latency to the byte stream.
module packet_reader_fifo
    import packet_buffer_reader_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  W     = BYTE_LEN,
    localparam int CW    = clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [W-1:0]  rdata_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q;
    logic          empty, bypass, wr_en, rd_en;

    assign empty   = (count_q == '0);
    assign valid_o = !empty || push_i;
    assign rdata_o = empty ? wdata_i : mem_q[rd_q];
    assign count_o = count_q;

    // A word that arrives into an empty FIFO and leaves in the same cycle is never stored.
    assign bypass  = empty && push_i && pop_i;
    assign wr_en   = push_i && !bypass;
    assign rd_en   = pop_i && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            if (rd_en) rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            count_q <= count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!(wr_en && !rd_en && count_q == CW'(DEPTH)));
    end

endmodule

// File: rtl/packet_buffer_reader.sv
// Packet buffer read sequencer: (addr, len) command -> credit-limited RAM reads -> byte stream.
// Optional PACKET_BUFFER_READER_STATS_EN adds pkt_count/byte_count outputs.
module packet_buffer_reader
    import packet_buffer_reader_pkg::*;
#(
    parameter int  RAM_SIZE     = PACKET_BUFFER_SIZE,
    parameter int  READ_LATENCY = PACKET_BUFFER_READ_LATENCY,
    parameter int  MAX_LEN      = PACKET_READER_MAX_LEN,
    localparam int AW           = clog2(RAM_SIZE),
    localparam int LW           = clog2(MAX_LEN + 1),
    localparam int DEPTH        = READ_LATENCY + 2,
    localparam int CW           = clog2(DEPTH + 1),
    localparam int FW           = clog2(READ_LATENCY + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [AW-1:0]       cmd_addr,
    input  logic [LW-1:0]       cmd_len,
    output logic                ram_read_req,
    output logic [AW-1:0]       ram_read_addr,
    input  logic                ram_read_ready,
    input  logic [BYTE_LEN-1:0] ram_read_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BYTE_LEN-1:0] out_data,
    output logic                out_last,
    output logic                busy,
`ifdef PACKET_BUFFER_READER_STATS_EN
    output logic [15:0]         pkt_count,
    output logic [31:0]         byte_count,
`endif
    output logic                done
);

    state_e        state_q, state_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic [AW-1:0] issue_addr_q, issue_addr_d;
    logic [LW-1:0] issue_left_q, issue_left_d;
    logic [LW-1:0] out_left_q, out_left_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic          done_q, done_d;

    logic                fifo_valid;
    logic [BYTE_LEN-1:0] fifo_data;
    logic [CW-1:0]       fifo_count;
    logic [CW:0]         credit_used;
    logic                push, issue, hs;

    // Returns during FLUSH are stale pulses from the driver's unreset delay line.
    assign push        = ram_read_ready && (state_q != FLUSH);
    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign issue       = (state_q == RUN) && (issue_left_q != '0) && (credit_used < (CW+1)'(DEPTH));
    assign hs          = fifo_valid && out_ready;

    packet_reader_fifo #(.DEPTH(DEPTH), .W(BYTE_LEN)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (ram_read_out),
        .pop_i   (out_ready),
        .valid_o (fifo_valid),
        .rdata_o (fifo_data),
        .count_o (fifo_count)
    );

    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q == RUN);
    assign ram_read_req  = issue;
    assign ram_read_addr = issue_addr_q;
    assign out_valid     = fifo_valid;
    assign out_data      = fifo_valid ? fifo_data : '0;
    assign out_last      = fifo_valid && (out_left_q == LW'(1));
    assign done          = done_q;

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        issue_addr_d = issue_addr_q;
        issue_left_d = issue_left_q;
        out_left_d   = out_left_q;
        done_d       = 1'b0;
        inflight_d   = inflight_q + CW'(issue) - CW'(push);
        if (issue) begin
            issue_addr_d = (issue_addr_q == AW'(RAM_SIZE - 1)) ? '0 : issue_addr_q + 1'b1;
            issue_left_d = issue_left_q - 1'b1;
        end
        if (hs) out_left_d = out_left_q - 1'b1;
        case (state_q)
            FLUSH: begin
                if (flush_cnt_q == FW'(READ_LATENCY - 1)) begin
                    state_d     = IDLE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (cmd_valid) begin
                    issue_addr_d = cmd_addr;
                    issue_left_d = cmd_len;
                    out_left_d   = cmd_len;
                    if (cmd_len == '0) done_d  = 1'b1;
                    else               state_d = RUN;
                end
            end
            RUN: begin
                if (hs && out_left_q == LW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = FLUSH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FLUSH;
            flush_cnt_q  <= '0;
            issue_addr_q <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            inflight_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            issue_addr_q <= issue_addr_d;
            issue_left_q <= issue_left_d;
            out_left_q   <= out_left_d;
            inflight_q   <= inflight_d;
            done_q       <= done_d;
        end
    end

`ifdef PACKET_BUFFER_READER_STATS_EN
    logic [15:0] pkt_count_q;
    logic [31:0] byte_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count_q  <= '0;
            byte_count_q <= '0;
        end else begin
            if (done_q) pkt_count_q  <= pkt_count_q + 1'b1;
            if (hs)     byte_count_q <= byte_count_q + 1'b1;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_packet_buffer_reader.sv
// Scoreboard bench for packet_buffer_reader with a behavioural fixed-latency RAM driver.
module tb_packet_buffer_reader;
    import packet_buffer_reader_pkg::*;

    localparam int RAM_SIZE = 64;
    localparam int L        = 2;
    localparam int MAX_LEN  = 2048;
    localparam int AW       = clog2(RAM_SIZE);
    localparam int LW       = clog2(MAX_LEN + 1);
    localparam int DEPTH    = L + 2;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    logic          clk, reset, cmd_valid, cmd_ready, ram_read_req, ram_read_ready;
    logic [AW-1:0] cmd_addr, ram_read_addr;
    logic [LW-1:0] cmd_len;
    logic [7:0]    ram_read_out, out_data;
    logic          out_valid, out_ready, out_last, busy, done;
`ifdef PACKET_BUFFER_READER_STATS_EN
    logic [15:0]   pkt_count;
    logic [31:0]   byte_count;
`endif

    packet_buffer_reader #(.RAM_SIZE(RAM_SIZE), .READ_LATENCY(L), .MAX_LEN(MAX_LEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .ram_read_req   (ram_read_req),
        .ram_read_addr  (ram_read_addr),
        .ram_read_ready (ram_read_ready),
        .ram_read_out   (ram_read_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .busy           (busy),
`ifdef PACKET_BUFFER_READER_STATS_EN
        .pkt_count      (pkt_count),
        .byte_count     (byte_count),
`endif
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM driver model: data and ready appear L cycles after the request; the delay line is not reset.
    logic [7:0] mem   [RAM_SIZE];
    logic       rdy_p [L];
    logic [7:0] dat_p [L];
    initial for (int i = 0; i < L; i++) begin rdy_p[i] = 1'b0; dat_p[i] = 8'h00; end
    always @(posedge clk) begin
        rdy_p[0] <= ram_read_req;
        dat_p[0] <= mem[ram_read_addr];
        for (int i = 1; i < L; i++) begin
            rdy_p[i] <= rdy_p[i-1];
            dat_p[i] <= dat_p[i-1];
        end
    end
    assign ram_read_ready = rdy_p[L-1];
    assign ram_read_out   = dat_p[L-1];

    int      n_chk = 0, n_fail = 0;
    exp_t    exp_q [$];
    logic [AW-1:0] addr_q [$];
    int      outstanding = 0, hs_cnt = 0, req_cnt = 0, done_cnt = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    task automatic monitor();
        exp_t e;
        logic [AW-1:0] a;
        forever begin
            @(negedge clk); #1;
            if (!reset) begin
                if (ram_read_req) begin
                    req_cnt++;
                    n_chk++;
                    if (addr_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL read_addr: unexpected read of %0d, none expected", ram_read_addr);
                    end else begin
                        a = addr_q.pop_front();
                        if (ram_read_addr !== a) begin
                            n_fail++;
                            $display("FAIL read_addr: got %0d expected %0d", ram_read_addr, a);
                        end
                    end
                end
                if (busy) begin
                    n_chk++;
                    if (outstanding + int'(ram_read_req) > DEPTH) begin
                        n_fail++;
                        $display("FAIL occupancy: got %0d limit %0d", outstanding + int'(ram_read_req), DEPTH);
                    end
                end
                if (stall_prev) begin
                    n_chk++;
                    if (out_valid !== 1'b1 || out_data !== stall_data) begin
                        n_fail++;
                        $display("FAIL stall_stable: valid=%0b data=%h expected valid=1 data=%h", out_valid, out_data, stall_data);
                    end
                end
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL out_byte: unexpected byte %h, none expected", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e.d || out_last !== e.last) begin
                            n_fail++;
                            $display("FAIL out_byte: got data=%h last=%0b expected data=%h last=%0b", out_data, out_last, e.d, e.last);
                        end
                    end
                end
                if (done) done_cnt++;
                outstanding += int'(ram_read_req) - int'(out_valid && out_ready);
                stall_prev = out_valid && !out_ready;
                stall_data = out_data;
            end
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        addr_q.delete();
        outstanding = 0;
        stall_prev  = 1'b0;
    endtask

    task automatic count_flush(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (cmd_ready) break;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic send_cmd(input int addr, input int len);
        int a;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = AW'(addr);
        cmd_len   = LW'(len);
        for (int k = 0; k < 100 && !cmd_ready; k++) @(negedge clk);
        @(posedge clk);
        for (int i = 0; i < len; i++) begin
            a = (addr + i) % RAM_SIZE;
            exp_q.push_back('{d: mem[a], last: (i == len - 1)});
            addr_q.push_back(AW'(a));
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input bit bp);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (bp) out_ready = (k % 4 == 0);
            if (done) begin seen = 1'b1; break; end
        end
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL done_timeout: done=0 expected 1 within 500 cycles"); end
        out_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: done=%0b expected 0", done); end
    endtask

    task automatic check_drained(input string name);
        n_chk++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: bytes left %0d reads left %0d expected 0 0", name, exp_q.size(), addr_q.size());
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({cmd_ready, busy, done, out_valid, out_last, ram_read_req} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: {cmd_ready,busy,done,valid,last,req}=%b expected 000000",
                     {cmd_ready, busy, done, out_valid, out_last, ram_read_req});
        end
        n_chk++;
        if (out_data !== 8'h00 || ram_read_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_data: out_data=%h read_addr=%0d expected 0 0", out_data, ram_read_addr);
        end
        reset = 1'b0;
        count_flush(n);
        n_chk++;
        if (n != L) begin n_fail++; $display("FAIL flush_len: cmd_ready low %0d cycles expected %0d", n, L); end
        clear_sb();
    endtask

    task automatic test_basic();
        int first, d0;
        for (int i = 0; i < 4; i++) mem[16 + i] = 8'hA0 + 8'(i);
        out_ready = 1'b1;
        d0 = done_cnt;
        first = 0;
        send_cmd(16, 4);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_chk++;
                if (ram_read_req !== 1'b1) begin n_fail++; $display("FAIL first_req: req=%0b expected 1 at cycle 1", ram_read_req); end
            end
            if (out_valid) begin first = k; break; end
        end
        n_chk++;
        if (first != 1 + L) begin n_fail++; $display("FAIL first_valid: cycle %0d expected %0d", first, 1 + L); end
        wait_done(1'b0);
        n_chk++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_count: %0d expected 1", done_cnt - d0); end
        check_drained("basic");
    endtask

    task automatic test_wrap();
        send_cmd(RAM_SIZE - 2, 4);
        wait_done(1'b0);
        check_drained("wrap");
    endtask

    task automatic test_backpressure();
        int h0;
        h0 = hs_cnt;
        out_ready = 1'b0;
        send_cmd(20, 16);
        wait_done(1'b1);
        n_chk++;
        if (hs_cnt - h0 != 16) begin n_fail++; $display("FAIL bp_bytes: got %0d expected 16", hs_cnt - h0); end
        check_drained("bp");
    endtask

    task automatic test_zero_len();
        int d0, r0;
        d0 = done_cnt;
        r0 = req_cnt;
        send_cmd(5, 0);
        @(negedge clk);
        n_chk++;
        if (done !== 1'b1 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done: done=%0b cmd_ready=%0b expected 1 1", done, cmd_ready);
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (req_cnt != r0 || done_cnt - d0 != 1 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_reads: reads=%0d dones=%0d cmd_ready=%0b expected 0 1 1", req_cnt - r0, done_cnt - d0, cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        int h0, h1, n;
        out_ready = 1'b1;
        h0 = hs_cnt;
        send_cmd(30, 10);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (hs_cnt - h0 >= 3) break;
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({cmd_ready, busy, done, out_valid, out_last, ram_read_req} !== 6'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_outputs: {cmd_ready,busy,done,valid,last,req}=%b data=%h expected 000000 00",
                     {cmd_ready, busy, done, out_valid, out_last, ram_read_req}, out_data);
        end
        reset = 1'b0;
        clear_sb();
        count_flush(n);
        n_chk++;
        if (n != L) begin n_fail++; $display("FAIL midreset_flush: cmd_ready low %0d cycles expected %0d", n, L); end
        h1 = hs_cnt;
        send_cmd(40, 2);
        wait_done(1'b0);
        n_chk++;
        if (hs_cnt - h1 != 2) begin n_fail++; $display("FAIL midreset_bytes: got %0d expected 2", hs_cnt - h1); end
        check_drained("midreset");
    endtask

`ifdef PACKET_BUFFER_READER_STATS_EN
    task automatic test_stats();
        int n;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_sb();
        count_flush(n);
        out_ready = 1'b1;
        send_cmd(8, 4);
        wait_done(1'b0);
        send_cmd(3, 0);
        repeat (2) @(negedge clk);
        send_cmd(50, 3);
        wait_done(1'b0);
        @(negedge clk);
        n_chk++;
        if (pkt_count !== 16'd3 || byte_count !== 32'd7) begin
            n_fail++;
            $display("FAIL stats: pkt_count=%0d byte_count=%0d expected 3 7", pkt_count, byte_count);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < RAM_SIZE; i++) mem[i] = 8'($urandom_range(0, 255));
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
`ifdef PACKET_BUFFER_READER_STATS_EN
        test_stats();
`endif
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
